// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: two writeback requesters, the clear
// control, and the registered write port that feeds the register file.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [4:0]        req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [4:0]        req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              clr_start;
    logic              busy;
    logic              rf_we3;
    logic [4:0]        rf_wa3;
    logic [DATA_W-1:0] rf_wd3;

    // Requester / controller side
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_start,
        input  req0_ready, req1_ready, busy,
        input  rf_we3, rf_wa3, rf_wd3
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_start,
        output req0_ready, req1_ready, busy,
        output rf_we3, rf_wa3, rf_wd3
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter. After reset (or on clr_start) it zeroes
// x1..x31 one register per cycle, then round-robin arbitrates between the
// ALU and load writeback requesters onto the single write port, one write
// per cycle with one cycle of latency. Writes to x0 are accepted but the
// write enable is suppressed.
module rf_write_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    rf_write_arbiter_if.slave   bus
);
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic              rr;
    logic              we_p1;
    logic [4:0]        wa_p1;
    logic [DATA_W-1:0] wd_p1;

    logic rdy0;
    logic rdy1;
    logic gnt0;
    logic gnt1;

    // Grant decode: only in RUN and never while a clear is being requested;
    // on contention rr picks the winner.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state == RUN && !bus.clr_start) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr)) begin
                rdy0 = 1'b1;
            end else if (bus.req1_valid) begin
                rdy1 = 1'b1;
            end
        end
    end

    assign gnt0 = bus.req0_valid && rdy0;
    assign gnt1 = bus.req1_valid && rdy1;

    // Sequencer: clear walk, arbitration pointer and the registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= 5'd1;
            rr    <= 1'b0;
            we_p1 <= 1'b0;
            wa_p1 <= '0;
            wd_p1 <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    // cnt wraps to 0 after 31; it is reloaded on re-entry.
                    we_p1 <= 1'b1;
                    wa_p1 <= cnt;
                    wd_p1 <= '0;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.clr_start) begin
                        state <= CLEAR;
                        cnt   <= 5'd1;
                        we_p1 <= 1'b0;
                    end else if (gnt0) begin
                        we_p1 <= (bus.req0_addr != 5'd0);
                        wa_p1 <= bus.req0_addr;
                        wd_p1 <= bus.req0_data;
                        rr    <= 1'b1;
                    end else if (gnt1) begin
                        we_p1 <= (bus.req1_addr != 5'd0);
                        wa_p1 <= bus.req1_addr;
                        wd_p1 <= bus.req1_data;
                        rr    <= 1'b0;
                    end else begin
                        // Idle cycle: address/data hold, only the enable drops.
                        we_p1 <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= 5'd1;
                    we_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.busy       = (state == CLEAR);
    assign bus.rf_we3     = we_p1;
    assign bus.rf_wa3     = wa_p1;
    assign bus.rf_wd3     = wd_p1;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset state, the clear walk, a table
// of arbitration vectors in RUN, and hand-written clear/reset sequences.
module tb_rf_write_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    rf_write_arbiter_if #(.DATA_W(32)) bus ();

    rf_write_arbiter #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic clr);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        bus.clr_start  = clr;
    endtask

    // Walks n clear cycles starting at address 1; glitches clr_start mid-way
    // when glitch is set (it must be ignored).
    task automatic clear_walk(input int n, input logic glitch);
        for (int i = 1; i <= n; i++) begin
            bus.clr_start = (glitch && i == 15);
            #1;
            chk("clr_busy_pre", {31'd0, bus.busy}, 32'd1);
            chk("clr_rdy0", {31'd0, bus.req0_ready}, 32'd0);
            chk("clr_rdy1", {31'd0, bus.req1_ready}, 32'd0);
            @(posedge clk);
            #1;
            bus.clr_start = 1'b0;
            chk("clr_we", {31'd0, bus.rf_we3}, 32'd1);
            chk("clr_wa", {27'd0, bus.rf_wa3}, i);
            chk("clr_wd", bus.rf_wd3, 32'd0);
            chk("clr_busy_post", {31'd0, bus.busy}, (i < 31) ? 32'd1 : 32'd0);
        end
    endtask

    // One cycle: drive, check readies combinationally, clock, check write port.
    task automatic step(input string name, input vec_t v);
        drive(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1, 1'b0);
        #1;
        chk({name, "_rdy0"}, {31'd0, bus.req0_ready}, {31'd0, v.r0});
        chk({name, "_rdy1"}, {31'd0, bus.req1_ready}, {31'd0, v.r1});
        @(posedge clk);
        #1;
        chk({name, "_we"}, {31'd0, bus.rf_we3}, {31'd0, v.we});
        chk({name, "_wa"}, {27'd0, bus.rf_wa3}, {27'd0, v.wa});
        chk({name, "_wd"}, bus.rf_wd3, v.wd);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          v0  a0     d0            v1  a1     d1            r0 r1 we wa     wd
        vecs[0]  = '{1, 5'd1, 32'h11,       1, 5'd2, 32'h22,       1, 0, 1, 5'd1, 32'h11};
        vecs[1]  = '{1, 5'd1, 32'h11,       1, 5'd2, 32'h22,       0, 1, 1, 5'd2, 32'h22};
        vecs[2]  = '{1, 5'd1, 32'h11,       1, 5'd2, 32'h22,       1, 0, 1, 5'd1, 32'h11};
        vecs[3]  = '{1, 5'd1, 32'h11,       1, 5'd2, 32'h22,       0, 1, 1, 5'd2, 32'h22};
        vecs[4]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,       1, 0, 1, 5'd5, 32'hDEADBEEF};
        vecs[5]  = '{0, 5'd9, 32'h99,       0, 5'd9, 32'h99,       0, 0, 0, 5'd5, 32'hDEADBEEF};
        vecs[6]  = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h12345678, 0, 1, 0, 5'd0, 32'h12345678};
        vecs[7]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h77,       0, 1, 1, 5'd7, 32'h77};
        vecs[8]  = '{1, 5'd3, 32'h33,       0, 5'd0, 32'h0,        1, 0, 1, 5'd3, 32'h33};
        vecs[9]  = '{0, 5'd0, 32'h0,        1, 5'd4, 32'h44,       0, 1, 1, 5'd4, 32'h44};
        vecs[10] = '{1, 5'd8, 32'h88,       1, 5'd9, 32'h99,       1, 0, 1, 5'd8, 32'h88};
        vecs[11] = '{1, 5'd0, 32'hAA,       0, 5'd0, 32'h0,        1, 0, 0, 5'd0, 32'hAA};

        // Reset state, with a requester asking to prove readies stay low
        reset_n = 1'b0;
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_we", {31'd0, bus.rf_we3}, 32'd0);
        chk("rst_wa", {27'd0, bus.rf_wa3}, 32'd0);
        chk("rst_wd", bus.rf_wd3, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Power-up clear walk, then one idle RUN edge
        clear_walk(31, 1'b0);
        #1;
        @(posedge clk);
        #1;
        chk("idle_we", {31'd0, bus.rf_we3}, 32'd0);
        chk("idle_wa", {27'd0, bus.rf_wa3}, 32'd31);

        // Arbitration table (rr starts at 0)
        for (int k = 0; k < 12; k++) begin
            step($sformatf("vec%0d", k), vecs[k]);
        end
        // rr is now 1

        // clr_start with req0 pending: no grant, clear starts next edge
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        chk("clrreq_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("clrreq_busy", {31'd0, bus.busy}, 32'd1);
        chk("clrreq_we", {31'd0, bus.rf_we3}, 32'd0);
        clear_walk(31, 1'b1);
        #1;
        chk("after_clr_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("after_clr_we", {31'd0, bus.rf_we3}, 32'd1);
        chk("after_clr_wa", {27'd0, bus.rf_wa3}, 32'd6);
        chk("after_clr_wd", bus.rf_wd3, 32'h66);
        // rr = 1; a clear must leave it alone
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        bus.clr_start = 1'b0;
        clear_walk(31, 1'b0);
        step("rr_kept", '{1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 1, 1, 5'd2, 32'h2});
        // rr = 0; one req0 grant makes it 1 before the reset test
        step("rr_set", '{1, 5'd12, 32'hC, 0, 5'd0, 32'h0, 1, 0, 1, 5'd12, 32'hC});

        // Reset during the clear write to address 10
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        bus.clr_start = 1'b0;
        clear_walk(10, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, bus.rf_we3}, 32'd0);
        chk("midrst_wa", {27'd0, bus.rf_wa3}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        clear_walk(31, 1'b0);
        // rr back to 0 after reset: req0 wins contention
        step("rr_rst", '{1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 0, 1, 5'd1, 32'h1});
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk is the sole clock, and reset_n is active-low and asynchronous.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_addr  input  5  requester 0 destination register.
REQ-006 req0_data  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-008 req1_valid, req1_addr, req1_data, req1_ready  same widths and directions  requester 1 (load writeback).
REQ-009 clr_start  input  1  request to zero registers 1..31.
REQ-010 busy  output  1  clear sequence in progress.
REQ-011 rf_we3  output  1  register-file write enable.
REQ-012 rf_wa3  output  5  register-file write address.
REQ-013 rf_wd3  output  32  register-file write data.

Function
REQ-014 The FSM SHALL have exactly two states, CLEAR and RUN, plus a 5-bit clear counter cnt and a 1-bit round-robin pointer rr.
REQ-015 busy SHALL be 1 exactly when state==CLEAR, decoded directly from the state register.
REQ-016 In CLEAR, each clock edge SHALL register rf_we3=1, rf_wa3=cnt, rf_wd3=0, then increment cnt.
REQ-017 When CLEAR registers cnt==31, state SHALL become RUN on that same edge.
- Result: exactly 31 writes, addresses 1..31 in ascending order.
REQ-018 In CLEAR, req0_ready and req1_ready SHALL be 0.
REQ-019 In RUN, readies SHALL be combinational from the current valids, rr and clr_start:
- only reqN_valid high -> reqN_ready=1.
- both valid -> ready to requester rr (rr=0 selects req0).
- clr_start=1 -> both readies 0.
REQ-020 A transfer SHALL occur when reqN_valid and reqN_ready are both 1.
- At most one transfer per cycle.
- Requesters SHALL hold valid, addr and data stable until ready.
REQ-021 On a transfer edge, rr SHALL be set to the index of the non-granted requester, whether or not the other requester was contending.
REQ-022 Write latency SHALL be one cycle: the edge ending a transfer cycle registers the granted addr and data onto rf_wa3/rf_wd3.
REQ-023 On that edge, rf_we3 SHALL be 1 unless the granted addr==0.
- A write to x0 is accepted (ready=1) but suppressed (rf_we3=0).
- rf_wa3=0 and rf_wd3=granted data are still registered.
REQ-024 A RUN cycle without a transfer SHALL register rf_we3=0, and rf_wa3/rf_wd3 SHALL hold their previous values.
REQ-025 clr_start=1 in RUN SHALL move state to CLEAR on the next edge with cnt=1, and that edge SHALL register rf_we3=0.
REQ-026 clr_start SHALL be ignored while in CLEAR; the sequence is not restarted or extended.
REQ-027 rr SHALL be unchanged by a CLEAR sequence.

Reset
REQ-028 While reset_n=0, the registers SHALL hold these values:
- state=CLEAR, cnt=1, rr=0.
- rf_we3=0, rf_wa3=0, rf_wd3=0.
- Hence busy=1 and both readies 0.
REQ-029 The first rising edge after reset_n deasserts SHALL register the first clear write (address 1).
REQ-030 Asserting reset_n mid-sequence or mid-transfer SHALL immediately force the REQ-028 values.
- Any in-flight registered write is discarded; rf_we3 drops to 0 asynchronously.
- The clear restarts from address 1 after deassertion.

Verification
REQ-031 Release reset, no requests -> rf_we3=1 for 31 consecutive edges with rf_wa3=1,2,...,31 and rf_wd3=0; busy falls after the edge writing 31; rf_we3=0 on the next edge.
REQ-032 RUN, req0 only, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next edge rf_we3=1, rf_wa3=5, rf_wd3=0xDEADBEEF.
REQ-033 RUN, both valid continuously for 4 cycles (req0 addr=1, req1 addr=2), rr=0 -> grants req0, req1, req0, req1; rf_wa3 sequence 1,2,1,2, each one edge late.
REQ-034 RUN, req1 valid, addr=0, data=0x12345678 -> req1_ready=1; next edge rf_we3=0, rf_wa3=0.
REQ-035 RUN, clr_start=1 with req0 valid -> req0_ready=0; busy=1 next cycle; 31 zero writes follow; req0 is granted in the first RUN cycle after.
REQ-036 reset_n pulsed low during clear write to address 10 -> rf_we3=0 immediately; after release, the clear restarts at address 1.
